// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default datapath widths, exponent limit and the
// normaliser case decode.
package fpu_pkg;

    localparam int MANT_W_DEF = 24;
    localparam int EXP_W_DEF  = 8;
    localparam int TAG_W_DEF  = 4;

    localparam logic [EXP_W_DEF-1:0] EXP_MAX = {EXP_W_DEF{1'b1}};

    typedef enum logic [2:0] {
        SPECIAL = 3'd0,
        ZERO    = 3'd1,
        CARRY   = 3'd2,
        NORMAL  = 3'd3,
        UNDER   = 3'd4
    } norm_case_e;

endpackage

// File: rtl/fpu_norm_pipe_if.sv
// Input and output handshake channels of the normaliser pipe.
interface fpu_norm_pipe_if
    import fpu_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W:0]   in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-2:0] out_frac;
    logic [EXP_W-1:0]  out_exp;
    logic [TAG_W-1:0]  out_tag;
    logic              out_zero;
    logic              out_ovf;
    logic              out_unf;
    logic              out_sticky;

    modport master (
        output in_valid, in_mant, in_exp, in_tag, out_ready,
        input  in_ready, out_valid, out_frac, out_exp, out_tag,
               out_zero, out_ovf, out_unf, out_sticky
    );

    modport slave (
        input  in_valid, in_mant, in_exp, in_tag, out_ready,
        output in_ready, out_valid, out_frac, out_exp, out_tag,
               out_zero, out_ovf, out_unf, out_sticky
    );
endinterface

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter, counted from the MSB; all-zero input
// returns W.
module fpu_lzc #(
    parameter int W     = 24,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic [W-1:0]     in_data,
    output logic [CNT_W-1:0] out_count
);

    logic found_s;

    // First set bit scanning down from the MSB wins.
    always_comb begin
        out_count = CNT_W'(W);
        found_s   = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found_s && in_data[i]) begin
                out_count = CNT_W'(W - 1 - i);
                found_s   = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fpu_norm_pipe.sv
// Two-stage post-arithmetic normaliser: S1 decodes and counts leading zeros,
// S2 shifts, adjusts the exponent and holds the outputs under backpressure.
module fpu_norm_pipe
    import fpu_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input logic            clk,
    input logic            rst_n,
    fpu_norm_pipe_if.slave bus
);

    localparam int LZ_W  = $clog2(MANT_W) + 1;
    localparam int CMP_W = ((LZ_W > EXP_W) ? LZ_W : EXP_W) + 1;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

    logic [LZ_W-1:0]   lz_s;
    logic [EXP_W-1:0]  e_s;
    norm_case_e        case_s;
    logic              out_adv_s, s1_adv_s, accept_s;

    logic              s1_valid_q, s1_valid_d;
    logic [MANT_W:0]   s1_mant_q, s1_mant_d;
    logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
    logic [LZ_W-1:0]   s1_lz_q, s1_lz_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    norm_case_e        s1_case_q, s1_case_d;

    logic [EXP_W-1:0]  e2_s;
    logic [EXP_W:0]    exp_p1_s, exp_sub_s;
    logic [MANT_W-1:0] mant_lo_s, shl_s;
    logic [MANT_W-2:0] res_frac_s;
    logic [EXP_W-1:0]  res_exp_s;
    logic              res_zero_s, res_ovf_s, res_unf_s, res_sticky_s;

    logic              out_valid_q, out_valid_d;
    logic [MANT_W-2:0] out_frac_q, out_frac_d;
    logic [EXP_W-1:0]  out_exp_q, out_exp_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              out_zero_q, out_zero_d, out_ovf_q, out_ovf_d;
    logic              out_unf_q, out_unf_d, out_sticky_q, out_sticky_d;

    fpu_lzc #(.W(MANT_W), .CNT_W(LZ_W)) u_lzc (
        .in_data   (bus.in_mant[MANT_W-1:0]),
        .out_count (lz_s)
    );

    assign out_adv_s    = !out_valid_q || bus.out_ready;
    assign s1_adv_s     = !s1_valid_q || out_adv_s;
    assign accept_s     = bus.in_valid && s1_adv_s;
    assign bus.in_ready = s1_adv_s;

    // Case decode on the incoming beat; exponent 0 behaves as 1 (denormal).
    always_comb begin
        e_s = (bus.in_exp == '0) ? EXP_W'(1'b1) : bus.in_exp;
        if (bus.in_exp == EXP_ONES) begin
            case_s = SPECIAL;
        end else if (bus.in_mant == '0) begin
            case_s = ZERO;
        end else if (bus.in_mant[MANT_W]) begin
            case_s = CARRY;
        end else if (CMP_W'(lz_s) < CMP_W'(e_s)) begin
            case_s = NORMAL;
        end else begin
            case_s = UNDER;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mant_d  = s1_mant_q;
        s1_exp_d   = s1_exp_q;
        s1_lz_d    = s1_lz_q;
        s1_tag_d   = s1_tag_q;
        s1_case_d  = s1_case_q;
        if (s1_adv_s) begin
            s1_valid_d = bus.in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (accept_s) begin
            s1_mant_d = bus.in_mant;
            s1_exp_d  = bus.in_exp;
            s1_lz_d   = lz_s;
            s1_tag_d  = bus.in_tag;
            s1_case_d = case_s;
        end else begin
            s1_case_d = s1_case_q;
        end
    end

    // S2 datapath: shift and exponent adjust at EXP_W+1 bits so nothing wraps.
    always_comb begin
        e2_s         = (s1_exp_q == '0) ? EXP_W'(1'b1) : s1_exp_q;
        mant_lo_s    = s1_mant_q[MANT_W-1:0];
        exp_p1_s     = {1'b0, s1_exp_q} + (EXP_W+1)'(1'b1);
        exp_sub_s    = {1'b0, e2_s} - (EXP_W+1)'(s1_lz_q);
        shl_s        = '0;
        res_frac_s   = '0;
        res_exp_s    = '0;
        res_zero_s   = 1'b0;
        res_ovf_s    = 1'b0;
        res_unf_s    = 1'b0;
        res_sticky_s = 1'b0;
        case (s1_case_q)
            SPECIAL: begin
                res_frac_s = s1_mant_q[MANT_W-2:0];
                res_exp_s  = EXP_ONES;
            end
            ZERO: begin
                res_zero_s = 1'b1;
            end
            CARRY: begin
                res_sticky_s = s1_mant_q[0];
                if (exp_p1_s == {1'b0, EXP_ONES}) begin
                    res_exp_s = EXP_ONES;
                    res_ovf_s = 1'b1;
                end else begin
                    res_frac_s = s1_mant_q[MANT_W-1:1];
                    res_exp_s  = exp_p1_s[EXP_W-1:0];
                end
            end
            NORMAL: begin
                shl_s      = mant_lo_s << s1_lz_q;
                res_frac_s = shl_s[MANT_W-2:0];
                res_exp_s  = exp_sub_s[EXP_W-1:0];
            end
            UNDER: begin
                shl_s      = mant_lo_s << (e2_s - EXP_W'(1'b1));
                res_frac_s = shl_s[MANT_W-2:0];
                res_unf_s  = 1'b1;
            end
            default: begin
                res_frac_s = '0;
            end
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_frac_d   = out_frac_q;
        out_exp_d    = out_exp_q;
        out_tag_d    = out_tag_q;
        out_zero_d   = out_zero_q;
        out_ovf_d    = out_ovf_q;
        out_unf_d    = out_unf_q;
        out_sticky_d = out_sticky_q;
        if (out_adv_s && s1_valid_q) begin
            out_valid_d  = 1'b1;
            out_frac_d   = res_frac_s;
            out_exp_d    = res_exp_s;
            out_tag_d    = s1_tag_q;
            out_zero_d   = res_zero_s;
            out_ovf_d    = res_ovf_s;
            out_unf_d    = res_unf_s;
            out_sticky_d = res_sticky_s;
        end else if (out_adv_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline state; reset drops every in-flight beat and clears the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_mant_q    <= '0;
            s1_exp_q     <= '0;
            s1_lz_q      <= '0;
            s1_tag_q     <= '0;
            s1_case_q    <= ZERO;
            out_valid_q  <= 1'b0;
            out_frac_q   <= '0;
            out_exp_q    <= '0;
            out_tag_q    <= '0;
            out_zero_q   <= 1'b0;
            out_ovf_q    <= 1'b0;
            out_unf_q    <= 1'b0;
            out_sticky_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_mant_q    <= s1_mant_d;
            s1_exp_q     <= s1_exp_d;
            s1_lz_q      <= s1_lz_d;
            s1_tag_q     <= s1_tag_d;
            s1_case_q    <= s1_case_d;
            out_valid_q  <= out_valid_d;
            out_frac_q   <= out_frac_d;
            out_exp_q    <= out_exp_d;
            out_tag_q    <= out_tag_d;
            out_zero_q   <= out_zero_d;
            out_ovf_q    <= out_ovf_d;
            out_unf_q    <= out_unf_d;
            out_sticky_q <= out_sticky_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_frac   = out_frac_q;
    assign bus.out_exp    = out_exp_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.out_unf    = out_unf_q;
    assign bus.out_sticky = out_sticky_q;

endmodule
